if_fetch_stage: RTL and testbench
=================================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000: first fetch address after reset.
REQ-002 SHALL have parameter QDEPTH, default 2: fetch-queue entries (power of 2, >=2).
REQ-003 SHALL have CLK  input  1: sole clock; all state updates on negedge CLK, matching the pipeline registers.
REQ-004 SHALL have RST  input  1: reset, synchronous, active-high.
REQ-005 SHALL have imem_req_valid  output  1 / imem_req_ready  input  1 / imem_req_addr  output  32: instruction-memory request handshake.
REQ-006 SHALL have imem_rsp_valid  input  1 / imem_rsp_data  input  32: in-order response, latency >=1 cycle, no backpressure.
REQ-007 SHALL have redirect_valid  input  1 / redirect_pc  input  32: taken branch/jump from EX; flushes fetch.
REQ-008 SHALL have stall  input  1: IF/ID hold; head entry not consumed.
REQ-009 SHALL have PC_if  output  32 / Inst_if  output  32 / valid_if  output  1 / halt_if  output  1: feed to IF/ID register.

Function
REQ-010 SHALL hold fetch PC (fpc); imem_req_addr = fpc; on req handshake fpc <= fpc+4 (mod 2^32, wrap silent).
REQ-011 SHALL assert imem_req_valid iff !halted && !redirect_valid && (occupancy + outstanding) < QDEPTH.
REQ-012 SHALL track outstanding (0..QDEPTH): +1 on req handshake, -1 on rsp_valid, both same cycle = unchanged.
REQ-013 SHALL enqueue {request PC, imem_rsp_data} on rsp_valid when drop_cnt==0; PC taken from an internal PC FIFO written at request.
REQ-014 SHALL, when drop_cnt>0, discard rsp_valid data and decrement drop_cnt.
REQ-015 SHALL present queue head combinationally: valid_if = !empty, PC_if/Inst_if = head fields; when empty PC_if=0, Inst_if=0.
REQ-016 SHALL dequeue head when valid_if && !stall; enqueue and dequeue same cycle on full queue SHALL both succeed.
REQ-017 SHALL, on redirect_valid: clear queue, fpc <= redirect_pc, drop_cnt <= outstanding after this cycle's handshake/response, halted <= 0; redirect wins over enqueue and stall.
REQ-018 SHALL assert halt_if = valid_if && head opcode not among the nine supported RV32I opcodes (0110011, 0010011, 1100011, 0000011, 1101111, 1100111, 0100011, 0110111, 0010111).
REQ-019 SHALL set halted when a halt_if entry is dequeued; while halted, no new requests; in-flight responses still enqueue.
REQ-020 SHALL, with stall held, keep PC_if/Inst_if/valid_if/halt_if stable.
REQ-021 SHALL achieve one instruction per cycle with 1-cycle memory, imem_req_ready=1, no stall.

Reset
REQ-022 SHALL, on RST=1 at negedge CLK: fpc=RESET_PC, queue empty, outstanding=0, drop_cnt=0, halted=0; thus valid_if=0, halt_if=0, PC_if=0, Inst_if=0, imem_req_valid=0 that cycle.
REQ-023 SHALL, on reset mid-operation, discard all in-flight responses that arrive after reset deasserts; the memory is reset concurrently by the same RST.

Configuration
REQ-024 SHALL, with JAL_PREDICT_EN defined, on enqueue of a JAL (opcode 1101111) redirect fpc to entry PC + J-immediate and set drop_cnt to remaining outstanding, queue entries older than and including the JAL kept.
REQ-025 SHALL, without JAL_PREDICT_EN, treat JAL as ordinary sequential fetch, EX redirect only.

Structure
REQ-026 SHALL take opcode constants and RESET_PC default from the shared pipeline package (same opcode defines as decode).
REQ-027 SHALL instantiate one sub-module fetch_queue (parametric depth FIFO of {PC,Inst} with flush); PC-tag FIFO reuses it.

Verification
REQ-028 Reset, mem latency 1, ready=1, ADDI stream -> valid_if high from cycle 2, PC_if 0,4,8,... one per cycle.
REQ-029 stall held 3 cycles while queue full -> imem_req_valid=0, PC_if/Inst_if unchanged, no loss after release.
REQ-030 redirect_pc=0x100 with 2 outstanding -> both responses dropped, next valid_if shows PC_if=0x100.
REQ-031 Inst 0x00000000 at PC 0x8 -> halt_if=1 with PC_if=0x8; after dequeue no further requests; redirect clears halted.
REQ-032 JAL_PREDICT_EN, JAL +16 at 0x4 -> next valid_if after JAL has PC_if=0x14; without macro -> 0x8.
REQ-033 imem_req_ready random 50%, latency 1-3 -> PC_if sequence strictly +4, no duplicates or gaps.

Source files
------------

// File: rtl/if_fetch_stage_pkg.sv
// rtl/if_fetch_stage_pkg.sv - shared pipeline constants, fetch entry type and opcode helpers
package if_fetch_stage_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // True for the opcodes the decode stage implements; anything else halts.
  function automatic logic is_rv32i_op(input logic [6:0] op);
    logic ok;
    ok = 1'b0;
    case (op)
      OP_REG, OP_IMM, OP_BRANCH, OP_LOAD, OP_JAL,
      OP_JALR, OP_STORE, OP_LUI, OP_AUIPC: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Sign-extended J-type immediate.
  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// rtl/if_fetch_stage_if.sv - instruction-memory request/response bundle
interface if_fetch_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/if_fetch_stage_fetch_queue.sv
// rtl/if_fetch_stage_fetch_queue.sv - power-of-2 FIFO with flush, head shown combinationally
module fetch_queue #(
  parameter int W = 64,
  parameter int D = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [W-1:0]       data_i,
  input  logic               pop_i,
  output logic [W-1:0]       head_o,
  output logic               empty_o,
  output logic [$clog2(D):0] count_o
);
  localparam int AW = $clog2(D);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i && ((cnt_q != FULL_CNT) || do_pop);

  // Pointer and count next state; flush empties the queue outright.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Pointer/count registers.
  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage, written only by an accepted push.
  always_ff @(negedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage; JAL_PREDICT_EN enables JAL redirect at enqueue
module if_fetch_stage
  import if_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          QDEPTH   = 2
) (
  input  logic                   CLK,
  input  logic                   RST,
  if_fetch_stage_if.master       imem,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   stall,
  output logic [31:0]            PC_if,
  output logic [31:0]            Inst_if,
  output logic                   valid_if,
  output logic                   halt_if
);
  localparam int          AW     = $clog2(QDEPTH);
  localparam int          CW     = AW + 1;
  localparam logic [CW:0] QLIMIT = (CW+1)'(QDEPTH);

  logic [31:0]   fpc_q, fpc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          halted_q, halted_d;

  fetch_entry_t  q_head, q_enq;
  logic          q_empty;
  logic [CW-1:0] q_count;
  logic [31:0]   t_head;
  logic          t_empty;
  logic [CW-1:0] t_count;
  logic          tag_unused;

  logic          req_hs, rsp_take, rsp_drop, enq, deq, jal_hit, tag_flush;
  logic [31:0]   jal_target;
  logic [CW:0]   occ_sum;

  assign valid_if = !q_empty;
  assign PC_if    = valid_if ? q_head.pc   : '0;
  assign Inst_if  = valid_if ? q_head.inst : '0;
  assign halt_if  = valid_if && !is_rv32i_op(q_head.inst[6:0]);
  assign deq      = valid_if && !stall;

  // Occupancy excludes an entry leaving this cycle so a 1-cycle memory streams one per cycle.
  assign occ_sum  = {1'b0, q_count} - {{CW{1'b0}}, deq} + {1'b0, out_q};

  assign imem.imem_req_valid = !RST && !halted_q && !redirect_valid && (occ_sum < QLIMIT);
  assign imem.imem_req_addr  = fpc_q;

  assign req_hs   = imem.imem_req_valid && imem.imem_req_ready;
  assign rsp_take = imem.imem_rsp_valid && (drop_q == '0);
  assign rsp_drop = imem.imem_rsp_valid && (drop_q != '0);
  assign enq      = rsp_take && !redirect_valid;
  assign q_enq    = '{pc: t_head, inst: imem.imem_rsp_data};
  assign out_d    = out_q + CW'(req_hs) - CW'(imem.imem_rsp_valid);

`ifdef JAL_PREDICT_EN
  assign jal_hit    = enq && (imem.imem_rsp_data[6:0] == OP_JAL);
  assign jal_target = t_head + j_imm(imem.imem_rsp_data);
`else
  assign jal_hit    = 1'b0;
  assign jal_target = t_head;
`endif

  // Every in-flight tag belongs to a response that will be dropped after a redirect.
  assign tag_flush  = redirect_valid || jal_hit;
  assign tag_unused = ^{t_count, t_empty};

  fetch_queue #(.W($bits(fetch_entry_t)), .D(QDEPTH)) u_inst_q (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (redirect_valid),
    .push_i  (enq),
    .data_i  (q_enq),
    .pop_i   (deq),
    .head_o  (q_head),
    .empty_o (q_empty),
    .count_o (q_count)
  );

  fetch_queue #(.W(32), .D(QDEPTH)) u_tag_q (
    .clk_i   (CLK),
    .rst_i   (RST),
    .flush_i (tag_flush),
    .push_i  (req_hs),
    .data_i  (fpc_q),
    .pop_i   (rsp_take),
    .head_o  (t_head),
    .empty_o (t_empty),
    .count_o (t_count)
  );

  // Fetch PC, drop count and halt next state; redirect overrides everything else.
  always_comb begin
    fpc_d    = fpc_q;
    drop_d   = drop_q;
    halted_d = halted_q;
    if (req_hs)          fpc_d    = fpc_q + 32'd4;
    if (rsp_drop)        drop_d   = drop_q - 1'b1;
    if (deq && halt_if)  halted_d = 1'b1;
    if (jal_hit) begin
      fpc_d  = jal_target;
      drop_d = out_d;
    end
    if (redirect_valid) begin
      fpc_d    = redirect_pc;
      drop_d   = out_d;
      halted_d = 1'b0;
    end
  end

  // Stage state registers.
  always_ff @(negedge CLK) begin
    if (RST) begin
      fpc_q    <= RESET_PC;
      out_q    <= '0;
      drop_q   <= '0;
      halted_q <= 1'b0;
    end else begin
      fpc_q    <= fpc_d;
      out_q    <= out_d;
      drop_q   <= drop_d;
      halted_q <= halted_d;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - self-checking bench with memory model and fetch scoreboard
module tb_if_fetch_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [31:0] PC_if, Inst_if;
  logic        valid_if, halt_if;

  if_fetch_stage_if imem();

  if_fetch_stage dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem           (imem),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .PC_if          (PC_if),
    .Inst_if        (Inst_if),
    .valid_if       (valid_if),
    .halt_if        (halt_if)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic [31:0] addr; int due; bit live; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  localparam logic [31:0] ADDI = 32'h0000_0013;
  localparam logic [31:0] JAL16 = 32'h0100_006F;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_due = -1;
  bit rand_ready = 0;
  int lat_min = 1, lat_max = 1, stall_pct = 0;
  pend_t pend[$];
  exp_t  sb[$];
  bit [31:0] prog [bit [31:0]];

  logic        o_req, o_valid, o_halt, o_cons, o_sb_ok;
  logic [31:0] o_addr, o_pc, o_inst, e_pc, e_inst;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (prog.exists(a)) return prog[a];
    return ADDI;
  endfunction

  // One clock cycle: drive at posedge, observe at posedge+1, DUT commits at negedge.
  task automatic run_cycle();
    pend_t p;
    exp_t e;
    bit jal_now;
    logic [31:0] d;
    int due;
    jal_now = 0;
    imem.imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    if (stall_pct > 0) stall = ($urandom_range(0, 99) < stall_pct);
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      d = mem_word(p.addr);
      imem.imem_rsp_valid = 1'b1;
      imem.imem_rsp_data  = d;
      if (p.live && !redirect_valid) begin
        sb.push_back('{pc: p.addr, inst: d});
`ifdef JAL_PREDICT_EN
        if (d[6:0] == 7'b1101111) jal_now = 1;
`endif
      end
    end else begin
      imem.imem_rsp_valid = 1'b0;
      imem.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #1;
    o_req   = imem.imem_req_valid;
    o_addr  = imem.imem_req_addr;
    o_valid = valid_if;
    o_pc    = PC_if;
    o_inst  = Inst_if;
    o_halt  = halt_if;
    o_cons  = valid_if && !stall && !redirect_valid;
    o_sb_ok = 0;
    e_pc    = '0;
    e_inst  = '0;
    if (o_cons && sb.size() > 0) begin
      e = sb.pop_front();
      o_sb_ok = 1;
      e_pc = e.pc;
      e_inst = e.inst;
    end
    if (redirect_valid) begin
      sb.delete();
      foreach (pend[i]) pend[i].live = 1'b0;
    end
    if (o_req && imem.imem_req_ready) begin
      due = cyc + $urandom_range(lat_min, lat_max);
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend.push_back('{addr: o_addr, due: due, live: 1'b1});
    end
    if (jal_now) foreach (pend[i]) pend[i].live = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    cyc++;
  endtask

  task automatic apply_reset();
    RST = 1'b1;
    redirect_valid = 1'b0;
    stall = 1'b0;
    stall_pct = 0;
    rand_ready = 0;
    lat_min = 1;
    lat_max = 1;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    repeat (2) begin
      @(negedge CLK);
      @(posedge CLK);
    end
    pend.delete();
    sb.delete();
    prog.delete();
    cyc = 0;
    last_due = -1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    imem.imem_req_ready = 1'b1;
    imem.imem_rsp_valid = 1'b0;
    imem.imem_rsp_data  = '0;
    @(negedge CLK);
    @(posedge CLK);
    #1;
    n_checks++; if (valid_if !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_if); else n_pass++;
    n_checks++; if (halt_if !== 1'b0) $display("FAIL rst_halt: got %b want 0", halt_if); else n_pass++;
    n_checks++; if (PC_if !== 32'h0) $display("FAIL rst_pc: got %h want 0", PC_if); else n_pass++;
    n_checks++; if (Inst_if !== 32'h0) $display("FAIL rst_inst: got %h want 0", Inst_if); else n_pass++;
    n_checks++; if (imem.imem_req_valid !== 1'b0) $display("FAIL rst_req_valid: got %b want 0", imem.imem_req_valid); else n_pass++;
    n_checks++; if (imem.imem_req_addr !== 32'h0) $display("FAIL rst_req_addr: got %h want 0", imem.imem_req_addr); else n_pass++;
  endtask

  task automatic test_stream();
    int first_valid;
    int n_cons;
    logic [31:0] seq;
    first_valid = -1;
    n_cons = 0;
    seq = 32'h0;
    apply_reset();
    repeat (12) begin
      run_cycle();
      if (o_valid && first_valid < 0) first_valid = cyc - 1;
      if (o_cons) begin
        n_checks++;
        if (!o_sb_ok || o_pc !== e_pc || o_inst !== e_inst)
          $display("FAIL stream_sb: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst);
        else n_pass++;
        n_checks++; if (o_pc !== seq) $display("FAIL stream_seq: got %h want %h", o_pc, seq); else n_pass++;
        seq += 32'd4;
        n_cons++;
      end
    end
    n_checks++; if (first_valid !== 2) $display("FAIL stream_first_valid: got %0d want 2", first_valid); else n_pass++;
    n_checks++; if (n_cons !== 10) $display("FAIL stream_throughput: got %0d want 10", n_cons); else n_pass++;
  endtask

  task automatic test_stall_full();
    int n_cons;
    logic [31:0] seq;
    apply_reset();
    stall = 1'b1;
    repeat (4) run_cycle();
    repeat (3) begin
      run_cycle();
      n_checks++; if (o_req !== 1'b0) $display("FAIL stall_req_valid: got %b want 0", o_req); else n_pass++;
      n_checks++; if (o_valid !== 1'b1) $display("FAIL stall_valid: got %b want 1", o_valid); else n_pass++;
      n_checks++; if (o_pc !== 32'h0) $display("FAIL stall_pc: got %h want 0", o_pc); else n_pass++;
      n_checks++; if (o_inst !== ADDI) $display("FAIL stall_inst: got %h want %h", o_inst, ADDI); else n_pass++;
    end
    stall = 1'b0;
    seq = 32'h0;
    n_cons = 0;
    repeat (10) begin
      run_cycle();
      if (o_cons) begin
        n_checks++;
        if (!o_sb_ok || o_pc !== e_pc || o_inst !== e_inst)
          $display("FAIL stall_release_sb: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst);
        else n_pass++;
        n_checks++; if (o_pc !== seq) $display("FAIL stall_release_seq: got %h want %h", o_pc, seq); else n_pass++;
        seq += 32'd4;
        n_cons++;
      end
    end
    n_checks++; if (n_cons < 8) $display("FAIL stall_release_count: got %0d want >=8", n_cons); else n_pass++;
  endtask

  task automatic test_redirect();
    bit found;
    logic [31:0] seq;
    apply_reset();
    lat_min = 3;
    lat_max = 3;
    run_cycle();
    run_cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    run_cycle();
    redirect_valid = 1'b0;
    n_checks++; if (o_req !== 1'b0) $display("FAIL redir_req_valid: got %b want 0", o_req); else n_pass++;
    found = 0;
    seq = 32'h100;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle();
      if (o_valid) begin
        found = 1;
        n_checks++; if (o_pc !== 32'h100) $display("FAIL redir_first_pc: got %h want 00000100", o_pc); else n_pass++;
      end
    end
    n_checks++; if (!found) $display("FAIL redir_timeout: got none want valid_if within 20 cycles"); else n_pass++;
    repeat (12) begin
      run_cycle();
      if (o_cons) begin
        seq += 32'd4;
        n_checks++;
        if (!o_sb_ok || o_pc !== e_pc || o_inst !== e_inst)
          $display("FAIL redir_sb: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst);
        else n_pass++;
        n_checks++; if (o_pc !== seq) $display("FAIL redir_seq: got %h want %h", o_pc, seq); else n_pass++;
      end
    end
  endtask

  task automatic test_halt();
    bit halt_seen, halt_deq, found;
    logic [31:0] halt_pc;
    int bad_halt, post_req;
    apply_reset();
    prog[32'h8] = 32'h0000_0000;
    halt_seen = 0;
    halt_deq = 0;
    halt_pc = '1;
    bad_halt = 0;
    post_req = 0;
    for (int i = 0; i < 14; i++) begin
      run_cycle();
      if (o_halt && (!o_valid || o_pc !== 32'h8)) bad_halt++;
      if (o_valid && o_halt && !halt_seen) begin
        halt_seen = 1;
        halt_pc = o_pc;
      end
      if (halt_deq && o_req) post_req++;
      if (o_cons && o_halt) halt_deq = 1;
      if (o_cons) begin
        n_checks++;
        if (!o_sb_ok || o_pc !== e_pc || o_inst !== e_inst)
          $display("FAIL halt_sb: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst);
        else n_pass++;
      end
    end
    n_checks++; if (!halt_seen) $display("FAIL halt_seen: got 0 want 1"); else n_pass++;
    n_checks++; if (halt_pc !== 32'h8) $display("FAIL halt_pc: got %h want 00000008", halt_pc); else n_pass++;
    n_checks++; if (bad_halt !== 0) $display("FAIL halt_spurious: got %0d want 0", bad_halt); else n_pass++;
    n_checks++; if (post_req !== 0) $display("FAIL halt_post_req: got %0d want 0", post_req); else n_pass++;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    run_cycle();
    redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      run_cycle();
      if (o_valid) begin
        found = 1;
        n_checks++; if (o_pc !== 32'h200) $display("FAIL halt_redir_pc: got %h want 00000200", o_pc); else n_pass++;
        n_checks++; if (o_halt !== 1'b0) $display("FAIL halt_redir_halt: got %b want 0", o_halt); else n_pass++;
      end
    end
    n_checks++; if (!found) $display("FAIL halt_redir_timeout: got none want valid_if within 20 cycles"); else n_pass++;
  endtask

  task automatic test_jal();
    bit saw_jal, got_next;
    logic [31:0] next_pc, exp_next;
`ifdef JAL_PREDICT_EN
    exp_next = 32'h14;
`else
    exp_next = 32'h8;
`endif
    apply_reset();
    prog[32'h4] = JAL16;
    saw_jal = 0;
    got_next = 0;
    next_pc = '1;
    for (int i = 0; i < 20 && !got_next; i++) begin
      run_cycle();
      if (o_cons) begin
        n_checks++;
        if (!o_sb_ok || o_pc !== e_pc || o_inst !== e_inst)
          $display("FAIL jal_sb: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst);
        else n_pass++;
        if (saw_jal) begin
          got_next = 1;
          next_pc = o_pc;
        end else if (o_pc == 32'h4 && o_inst == JAL16) begin
          saw_jal = 1;
        end
      end
    end
    n_checks++; if (!saw_jal) $display("FAIL jal_seen: got 0 want 1"); else n_pass++;
    n_checks++; if (!got_next) $display("FAIL jal_next_timeout: got none want entry after JAL"); else n_pass++;
    n_checks++; if (next_pc !== exp_next) $display("FAIL jal_next_pc: got %h want %h", next_pc, exp_next); else n_pass++;
  endtask

  task automatic test_random();
    logic [31:0] seq;
    int n_cons;
    apply_reset();
    rand_ready = 1;
    lat_min = 1;
    lat_max = 3;
    stall_pct = 20;
    seq = 32'h0;
    n_cons = 0;
    repeat (400) begin
      run_cycle();
      if (o_cons) begin
        n_checks++;
        if (!o_sb_ok || o_pc !== e_pc || o_inst !== e_inst)
          $display("FAIL rand_sb: got %h/%h want %h/%h", o_pc, o_inst, e_pc, e_inst);
        else n_pass++;
        n_checks++; if (o_pc !== seq) $display("FAIL rand_seq: got %h want %h", o_pc, seq); else n_pass++;
        seq += 32'd4;
        n_cons++;
      end
    end
    stall_pct = 0;
    stall = 1'b0;
    n_checks++; if (n_cons < 40) $display("FAIL rand_progress: got %0d want >=40", n_cons); else n_pass++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall_full();
    test_redirect();
    test_halt();
    test_jal();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
